uart_bus_ctrl: RTL and testbench
================================

Name: uart_bus_ctrl

Overview:
- Memory-mapped UART controller between the CPU data bus and the UART receiver/sender pair.
- Buffers outgoing bytes in a small TX FIFO and sequences the sender's TXEn/TXStatus handshake.
- Captures received bytes into a holding register and raises a level interrupt.
- Replaces the fixed echo behaviour with CPU-driven send/receive.

Parameters:
- TXD_ADDR, 32'h4000_0018: TX data register address (write-only).
- RXD_ADDR, 32'h4000_001C: RX data register address (read-only).
- CON_ADDR, 32'h4000_0020: control/status register address.
- TX_DEPTH, 4: TX FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  bus address.
- wdata  in  32  bus write data; only bits [7:0] are used for TXD.
- MemRead  in  1  bus read strobe.
- MemWrite  in  1  bus write strobe.
- rdata  out  32  combinational read data; 0 for unmapped addresses.
- baud_tick  in  1  one-clk pulse per baud period; the sender samples TXEn on it.
- RXStatus  in  1  receiver byte-valid; asynchronous to clk.
- RXData  in  8  received byte; stable while RXStatus is high.
- TXStatus  in  1  sender idle (1) / busy (0); asynchronous to clk.
- TXData  out  8  byte presented to the sender.
- TXEn  out  1  send request to the sender.
- irq  out  1  level interrupt.

Behaviour:
- Reset values: TXData=8'hFF, TXEn=0, irq=0, FIFO empty, all CON bits 0, TX FSM in IDLE.
- RXStatus and TXStatus each pass through a 2-flop synchronizer before use.
- CON layout:
  - [0] tx_ie, R/W.
  - [1] rx_ie, R/W.
  - [2] tx_done, R; cleared by reading CON.
  - [3] rx_ready, R.
  - [4] tx_busy, R: FSM not IDLE or FIFO non-empty.
  - [5] overrun, R; cleared by reading CON.
  - [6] fifo_full, R.
  - Bits [31:7] read as 0.
- Writing CON updates only bits [1:0].
- Write to TXD: pushes wdata[7:0] if the FIFO is not full. When full, the write is dropped and the FIFO is unchanged.
- Read of RXD: rdata={24'b0,rx_byte}. On that clock edge rx_ready clears.
- Read side effects apply on the clk edge while MemRead is high. rdata returns pre-edge values.
- RX capture: on a synchronized RXStatus rising edge, rx_byte<=RXData and rx_ready<=1.
  - If rx_ready is already 1, the new byte is dropped, rx_byte is kept, and overrun<=1.
  - If an RXD read and a capture edge occur in the same cycle, the read returns the old byte, the new byte is captured, and rx_ready stays 1.
- TX FSM:
  - IDLE: if FIFO non-empty and sync TXStatus=1, pop the FIFO head into TXData and go to ARM.
  - ARM: TXEn=1. On the cycle after a baud_tick, TXEn=0 and go to WAIT_START. TXEn therefore spans exactly one baud_tick.
  - WAIT_START: wait for sync TXStatus=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for sync TXStatus=1, then set tx_done=1 and go to IDLE.
  - TXData holds its value until the next pop.
- Simultaneous FIFO push and pop in one cycle are both performed; the count is unchanged. A push to a full FIFO is dropped even when a pop occurs in the same cycle.
- If reading CON coincides with a tx_done or overrun set event, the set wins and the bit reads 1 afterwards.
- irq=(tx_ie&tx_done)|(rx_ie&rx_ready), registered, with 1-cycle latency.
- Reset asserted mid-transmission forces TXEn=0 and IDLE immediately. The sender is not otherwise notified.
- Pointer arithmetic: log2(TX_DEPTH)-bit pointers that wrap, plus a count of log2(TX_DEPTH)+1 bits.

Decomposition:
- Package uart_pkg holds:
  - Address constants.
  - CON bit-index localparams.
  - TX FSM state encoding: IDLE, ARM, WAIT_START, WAIT_DONE.
- Sub-module uart_tx_fifo: synchronous FIFO, parameterised by depth, with push, pop, full, empty and count.
- Synchronizers stay inline.

Test Plan:
- Reset -> TXData=FF, TXEn=0, irq=0, CON reads 0.
- Write TXD=0x41 with TXStatus=1 -> TXEn rises within 4 clk and falls the cycle after the next baud_tick.
  - Model the sender dropping TXStatus and returning it -> tx_done=1.
  - With tx_ie=1, irq=1. Reading CON clears tx_done and irq.
- Write 5 bytes 0x01..0x05 back-to-back, TX_DEPTH=4, sender held busy:
  - Cycle ordering matters: whether byte 0x01 has already been popped when byte 5 arrives decides whether byte 5 is accepted.
  - With TXStatus=0 from the start, 0x01..0x04 are accepted and 0x05 is dropped; fifo_full=1.
  - After release, the transmit order is 01, 02, 03, 04.
- RX: pulse RXStatus with RXData=0x5A -> rx_ready=1; an RXD read returns 0x5A and rx_ready clears.
- RX overrun: two RXStatus pulses (0x11 then 0x22) with no read -> RXD reads 0x11 and overrun=1.
  - A CON read clears overrun.
- Assert reset while in ARM -> TXEn=0 asynchronously, FIFO empty, FSM IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: bus addresses, CON bit positions and TX FSM states shared by the UART controller
package uart_pkg;
  localparam logic [31:0] TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] CON_ADDR = 32'h4000_0020;
  localparam int CON_TX_IE     = 0;
  localparam int CON_RX_IE     = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_READY  = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_OVERRUN   = 5;
  localparam int CON_FIFO_FULL = 6;
  typedef enum logic [1:0] {IDLE, ARM, WAIT_START, WAIT_DONE} tx_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with wrapping pointers; pushes while full are dropped
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    wp_d = do_push ? wp_q + AW'(1) : wp_q;
    rp_d = do_pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout = mem_q[rp_q];
    count = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: memory-mapped UART controller with TX FIFO, sender handshake FSM and RX holding register
module uart_bus_ctrl
  import uart_pkg::*;
#(
  parameter int TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rdata,
  input  logic        baud_tick,
  input  logic        RXStatus,
  input  logic [7:0]  RXData,
  input  logic        TXStatus,
  output logic [7:0]  TXData,
  output logic        TXEn,
  output logic        irq
);
  localparam int AW = $clog2(TX_DEPTH);
  tx_state_e state_q, state_d;
  logic rx_s1_q, rx_s2_q, rx_s3_q, tx_s1_q, tx_s2_q;
  logic [7:0] rx_byte_q, rx_byte_d, tx_data_q, tx_data_d, fifo_dout;
  logic rx_ready_q, rx_ready_d, overrun_q, overrun_d, tx_done_q, tx_done_d;
  logic tx_ie_q, tx_ie_d, rx_ie_q, rx_ie_d, txen_q, txen_d, irq_q, irq_d;
  logic wr_txd, wr_con, rd_rxd, rd_con, rx_edge, ovr_set, done_set, pop;
  logic fifo_full, fifo_empty, tx_busy;
  logic [AW:0] fifo_cnt;
  logic [31:0] con_rd;
  logic unused;
  assign unused = ^wdata[31:8];
  uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(reset),
    .push(wr_txd),
    .din(wdata[7:0]),
    .pop(pop),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );
  always_comb begin
    wr_txd = MemWrite && addr == TXD_ADDR;
    wr_con = MemWrite && addr == CON_ADDR;
    rd_rxd = MemRead && addr == RXD_ADDR;
    rd_con = MemRead && addr == CON_ADDR;
    rx_edge = rx_s2_q && !rx_s3_q;
    ovr_set = rx_edge && rx_ready_q && !rd_rxd;
    done_set = state_q == WAIT_DONE && tx_s2_q;
    pop = state_q == IDLE && !fifo_empty && tx_s2_q;
    tx_busy = state_q != IDLE || fifo_cnt != '0;
    rx_byte_d = rx_edge && !ovr_set ? RXData : rx_byte_q;
    rx_ready_d = rx_edge || (rx_ready_q && !rd_rxd);
    overrun_d = ovr_set || (overrun_q && !rd_con);
    tx_done_d = done_set || (tx_done_q && !rd_con);
    tx_ie_d = wr_con ? wdata[0] : tx_ie_q;
    rx_ie_d = wr_con ? wdata[1] : rx_ie_q;
    tx_data_d = pop ? fifo_dout : tx_data_q;
    irq_d = (tx_ie_q && tx_done_q) || (rx_ie_q && rx_ready_q);
    state_d = pop ? ARM
            : (state_q == ARM && baud_tick) ? WAIT_START
            : (state_q == WAIT_START && !tx_s2_q) ? WAIT_DONE
            : done_set ? IDLE : state_q;
    txen_d = state_d == ARM;
    con_rd = '0;
    con_rd[CON_TX_IE] = tx_ie_q;
    con_rd[CON_RX_IE] = rx_ie_q;
    con_rd[CON_TX_DONE] = tx_done_q;
    con_rd[CON_RX_READY] = rx_ready_q;
    con_rd[CON_TX_BUSY] = tx_busy;
    con_rd[CON_OVERRUN] = overrun_q;
    con_rd[CON_FIFO_FULL] = fifo_full;
    rdata = addr == RXD_ADDR ? {24'b0, rx_byte_q} : addr == CON_ADDR ? con_rd : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rx_s1_q <= 1'b0;
      rx_s2_q <= 1'b0;
      rx_s3_q <= 1'b0;
      tx_s1_q <= 1'b0;
      tx_s2_q <= 1'b0;
      rx_byte_q <= '0;
      tx_data_q <= 8'hFF;
      rx_ready_q <= 1'b0;
      overrun_q <= 1'b0;
      tx_done_q <= 1'b0;
      tx_ie_q <= 1'b0;
      rx_ie_q <= 1'b0;
      txen_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_s1_q <= RXStatus;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      tx_s1_q <= TXStatus;
      tx_s2_q <= tx_s1_q;
      rx_byte_q <= rx_byte_d;
      tx_data_q <= tx_data_d;
      rx_ready_q <= rx_ready_d;
      overrun_q <= overrun_d;
      tx_done_q <= tx_done_d;
      tx_ie_q <= tx_ie_d;
      rx_ie_q <= rx_ie_d;
      txen_q <= txen_d;
      irq_q <= irq_d;
    end
  end
  assign TXData = tx_data_q;
  assign TXEn = txen_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_uart_bus_ctrl.sv
// tb_uart_bus_ctrl: randomized self-checking bench against a transaction-level model of the UART controller
module tb_uart_bus_ctrl;
  import uart_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic MemRead = 1'b0, MemWrite = 1'b0, baud_tick = 1'b0, RXStatus = 1'b0;
  logic TXStatus, TXEn, irq;
  logic [7:0] RXData = '0, TXData;
  logic baud_en = 1'b1, hold_busy = 1'b0, snd_idle = 1'b1;
  int n_vec = 0, n_err = 0;
  logic [7:0] sent[$], exp_q[$];
  logic [7:0] m_rx_byte = '0;
  logic m_rx_ready = 0, m_ovr = 0, m_done = 0, m_tx_ie = 0, m_rx_ie = 0;
  assign TXStatus = snd_idle && !hold_busy;
  always #5 clk = ~clk;
  uart_bus_ctrl dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .MemRead(MemRead),
    .MemWrite(MemWrite), .rdata(rdata), .baud_tick(baud_tick), .RXStatus(RXStatus),
    .RXData(RXData), .TXStatus(TXStatus), .TXData(TXData), .TXEn(TXEn), .irq(irq)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    MemWrite = 1'b1;
    cyc(1);
    MemWrite = 1'b0;
  endtask
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    MemRead = 1'b1;
    #1 d = rdata;
    cyc(1);
    MemRead = 1'b0;
  endtask
  function automatic logic [31:0] con_exp(input logic full, input logic busy);
    return {25'b0, full, m_ovr, busy, m_rx_ready, m_done, m_rx_ie, m_tx_ie};
  endfunction
  task automatic read_con(input string tag, input logic full, input logic busy);
    logic [31:0] d;
    bus_read(CON_ADDR, d);
    chk(tag, d, con_exp(full, busy));
    m_ovr = 0;
    m_done = 0;
  endtask
  task automatic read_rxd(input string tag);
    logic [31:0] d;
    bus_read(RXD_ADDR, d);
    chk(tag, d, {24'b0, m_rx_byte});
    m_rx_ready = 0;
  endtask
  task automatic rx_pulse(input logic [7:0] b);
    RXData = b;
    RXStatus = 1'b1;
    cyc(4);
    RXStatus = 1'b0;
    cyc(4);
    if (m_rx_ready) m_ovr = 1;
    else begin
      m_rx_byte = b;
      m_rx_ready = 1;
    end
  endtask
  task automatic chk_irq(input string tag);
    cyc(2);
    chk(tag, 32'(irq), 32'((m_tx_ie & m_done) | (m_rx_ie & m_rx_ready)));
  endtask
  task automatic wait_sent(input string tag, input int n);
    int k = 0;
    while (sent.size() < n && k < 400) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(sent.size()), 32'(n));
    cyc(12);
    m_done = 1;
  endtask
  initial begin
    int bcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      bcnt = (bcnt + 1) % 7;
      baud_tick = baud_en && bcnt == 0;
    end
  end
  initial begin
    int busy_left = 0;
    forever begin
      @(posedge clk);
      if (snd_idle && baud_tick && TXEn) begin
        sent.push_back(TXData);
        #1 snd_idle = 1'b0;
        busy_left = 6;
      end else if (!snd_idle) begin
        #1 busy_left--;
        if (busy_left == 0) snd_idle = 1'b1;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int k, n;
    logic [7:0] v;
    #2 reset = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(2);
    chk("rst_txdata", 32'(TXData), 32'hFF);
    chk("rst_txen", 32'(TXEn), 0);
    chk("rst_irq", 32'(irq), 0);
    read_con("rst_con", 0, 0);
    bus_write(CON_ADDR, 32'h1);
    m_tx_ie = 1;
    bus_write(TXD_ADDR, 32'h41);
    k = 0;
    while (!TXEn && k < 4) begin
      @(negedge clk);
      k++;
    end
    chk("txen_rise", 32'(TXEn), 1);
    chk("txdata_41", 32'(TXData), 32'h41);
    k = 0;
    while (!baud_tick && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("txen_at_tick", 32'(TXEn), 1);
    @(negedge clk);
    chk("txen_fall", 32'(TXEn), 0);
    wait_sent("sent_41_n", 1);
    chk("sent_41", 32'(sent[0]), 32'h41);
    sent.delete();
    chk_irq("irq_done");
    read_con("con_done", 0, 0);
    chk_irq("irq_clr");
    read_con("con_after_clr", 0, 0);
    hold_busy = 1'b1;
    cyc(3);
    for (int i = 1; i <= 5; i++) bus_write(TXD_ADDR, 32'(i));
    read_con("con_full", 1, 1);
    hold_busy = 1'b0;
    wait_sent("fill_n", 4);
    for (int i = 0; i < 4; i++) chk("fill_order", 32'(sent[i]), 32'(i + 1));
    sent.delete();
    read_con("con_drain", 0, 0);
    rx_pulse(8'h5A);
    read_con("rx_ready_set", 0, 0);
    read_rxd("rx_5a");
    read_con("rx_ready_clr", 0, 0);
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    read_rxd("ovr_rxd");
    read_con("ovr_con", 0, 0);
    read_con("ovr_clr", 0, 0);
    bus_write(CON_ADDR, 32'h3);
    m_rx_ie = 1;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: rx_pulse(8'($urandom));
        1: read_rxd("rnd_rxd");
        default: read_con("rnd_con", 0, 0);
      endcase
      chk_irq("rnd_irq");
    end
    read_rxd("rx_flush");
    read_con("con_flush", 0, 0);
    for (int b = 0; b < 4; b++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        v = 8'($urandom);
        exp_q.push_back(v);
        bus_write(TXD_ADDR, {24'b0, v});
      end
      wait_sent("burst_n", exp_q.size());
      for (int j = 0; j < exp_q.size() && j < sent.size(); j++) chk("burst_byte", 32'(sent[j]), 32'(exp_q[j]));
      chk_irq("burst_irq");
      read_con("burst_con", 0, 0);
      sent.delete();
      exp_q.delete();
    end
    baud_en = 1'b0;
    cyc(2);
    bus_write(TXD_ADDR, 32'hC3);
    k = 0;
    while (!TXEn && k < 4) begin
      @(negedge clk);
      k++;
    end
    chk("arm_txen", 32'(TXEn), 1);
    #2 reset = 1'b0;
    #1 chk("arst_txen", 32'(TXEn), 0);
    chk("arst_txdata", 32'(TXData), 32'hFF);
    addr = CON_ADDR;
    #1 chk("arst_con", rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    m_tx_ie = 0;
    m_rx_ie = 0;
    m_done = 0;
    m_ovr = 0;
    m_rx_ready = 0;
    baud_en = 1'b1;
    cyc(30);
    chk("no_send_after_rst", 32'(sent.size()), 0);
    read_con("post_rst_con", 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
